// File: rtl/q_learning_acc.sv
// Single-entry Q-learning update engine: scans max Q(s',k), computes the TD update
// for Q(s,a) with saturation and writes it back into an on-chip Q-table.
module q_learning_acc #(
    parameter int unsigned S_W   = 6,
    parameter int unsigned A_W   = 4,
    parameter int unsigned N_ACT = 4,
    parameter int unsigned Q_W   = 16,
    parameter int unsigned F_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [A_W-1:0]        action,
    input  logic [S_W-1:0]        state,
    input  logic [S_W-1:0]        next_state,
    input  logic signed [Q_W-1:0] reward,
    input  logic [F_W-1:0]        gamma,
    input  logic [F_W-1:0]        alpha,
    output logic signed [Q_W-1:0] result,
    output logic                  done,
    output logic                  busy
);

    localparam int unsigned ADDR_W = S_W + A_W;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned I_W    = Q_W + F_W + 4;

    localparam logic signed [I_W-1:0] SAT_HI   = I_W'((2 ** (Q_W - 1)) - 1);
    localparam logic signed [I_W-1:0] SAT_LO   = I_W'(-(2 ** (Q_W - 1)));
    localparam logic signed [Q_W-1:0] MOST_NEG = {1'b1, {(Q_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        CALC,
        WRITE
    } fsm_t;

    fsm_t fsm_q, fsm_d;

    logic [S_W-1:0]        s_r;
    logic [A_W-1:0]        a_r;
    logic [S_W-1:0]        sn_r;
    logic signed [Q_W-1:0] r_r;
    logic [F_W-1:0]        alpha_r;
    logic [F_W-1:0]        gamma_r;
    logic signed [Q_W-1:0] max_r;
    logic signed [Q_W-1:0] qsa_r;
    logic [A_W-1:0]        scan_idx;

    logic signed [Q_W-1:0] q_mem [DEPTH];
    logic [DEPTH-1:0]      q_vld;

    logic [ADDR_W-1:0]     scan_addr;
    logic [ADDR_W-1:0]     sa_addr;
    logic signed [Q_W-1:0] scan_rd;
    logic signed [Q_W-1:0] sa_rd;

    logic signed [I_W-1:0] max_x, r_x, qsa_x, g_x, a_x;
    logic signed [I_W-1:0] target, td, upd_x;
    logic signed [Q_W-1:0] upd_sat;

    assign scan_addr = {sn_r, scan_idx};
    assign sa_addr   = {s_r, a_r};

    // Entries never written since reset read as zero
    always_comb begin
        scan_rd = q_vld[scan_addr] ? q_mem[scan_addr] : '0;
        sa_rd   = q_vld[sa_addr] ? q_mem[sa_addr] : '0;
    end

    // TD update in wide signed arithmetic, then clamp back to Q_W
    always_comb begin
        max_x  = I_W'(max_r);
        r_x    = I_W'(r_r);
        qsa_x  = I_W'(qsa_r);
        g_x    = I_W'({1'b0, gamma_r});
        a_x    = I_W'({1'b0, alpha_r});
        target = r_x + ((g_x * max_x) >>> F_W);
        td     = target - qsa_x;
        upd_x  = qsa_x + ((a_x * td) >>> F_W);
        if (upd_x > SAT_HI) begin
            upd_sat = {1'b0, {(Q_W - 1){1'b1}}};
        end else if (upd_x < SAT_LO) begin
            upd_sat = MOST_NEG;
        end else begin
            upd_sat = upd_x[Q_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (en) fsm_d = SCAN;
            SCAN:    if (scan_idx == A_W'(N_ACT - 1)) fsm_d = CALC;
            CALC:    fsm_d = WRITE;
            WRITE:   fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Operand latch, max scan, result/valid bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            q_vld    <= '0;
            result   <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            scan_idx <= '0;
            max_r    <= MOST_NEG;
        end else begin
            done <= (fsm_q == CALC);
            busy <= (fsm_d != IDLE);
            case (fsm_q)
                IDLE: begin
                    if (en) begin
                        s_r      <= state;
                        a_r      <= action;
                        sn_r     <= next_state;
                        r_r      <= reward;
                        alpha_r  <= alpha;
                        gamma_r  <= gamma;
                        max_r    <= MOST_NEG;
                        scan_idx <= '0;
                    end
                end
                SCAN: begin
                    if (scan_rd > max_r) max_r <= scan_rd;
                    if (scan_idx == '0) qsa_r <= sa_rd;
                    scan_idx <= scan_idx + A_W'(1);
                end
                CALC:    result <= upd_sat;
                WRITE:   q_vld[sa_addr] <= 1'b1;
                default: ;
            endcase
        end
    end

    // Table write lands at the end of WRITE so a same-entry scan always sees the old value
    always_ff @(posedge clk) begin
        if (!rst && fsm_q == WRITE) begin
            q_mem[sa_addr] <= result;
        end
    end

endmodule

// File: tb/tb_q_learning_acc.sv
// Bench for q_learning_acc: per-cycle comparison against a table-level Q-learning
// model plus directed updates with hand-computed results.
module tb_q_learning_acc;

    localparam int unsigned S_W   = 6;
    localparam int unsigned A_W   = 4;
    localparam int unsigned N_ACT = 4;
    localparam int unsigned Q_W   = 16;
    localparam int unsigned F_W   = 4;
    localparam int          NENT  = 1 << (S_W + A_W);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic [A_W-1:0]        action;
    logic [S_W-1:0]        state;
    logic [S_W-1:0]        next_state;
    logic signed [Q_W-1:0] reward;
    logic [F_W-1:0]        gamma;
    logic [F_W-1:0]        alpha;
    logic signed [Q_W-1:0] result;
    logic                  done;
    logic                  busy;

    always #5 clk = ~clk;

    q_learning_acc #(
        .S_W(S_W), .A_W(A_W), .N_ACT(N_ACT), .Q_W(Q_W), .F_W(F_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .action(action), .state(state),
        .next_state(next_state), .reward(reward), .gamma(gamma), .alpha(alpha),
        .result(result), .done(done), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: plain integer Q-table, countdown of remaining busy cycles per update
    int q_tbl [NENT];
    int remain  = 0;
    int pend    = 0;
    int pend_at = 0;
    int res_exp = 0;
    bit armed   = 1'b0;

    function automatic int fdiv16(input int x);
        if (x >= 0) return x / 16;
        return -((-x + 15) / 16);
    endfunction

    function automatic int model_update(input int s, input int a, input int sn,
                                        input int r, input int al, input int g);
        int qsa, mx, tgt, tdv, upd;
        qsa = q_tbl[s * (1 << A_W) + a];
        mx  = q_tbl[sn * (1 << A_W)];
        for (int k = 1; k < int'(N_ACT); k++)
            if (q_tbl[sn * (1 << A_W) + k] > mx) mx = q_tbl[sn * (1 << A_W) + k];
        tgt = r + fdiv16(g * mx);
        tdv = tgt - qsa;
        upd = qsa + fdiv16(al * tdv);
        if (upd > 32767) upd = 32767;
        if (upd < -32768) upd = -32768;
        return upd;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            foreach (q_tbl[i]) q_tbl[i] = 0;
            remain  = 0;
            res_exp = 0;
            armed   = 1'b1;
        end else if (remain > 0) begin
            remain--;
            if (remain == 1) res_exp = pend;
            if (remain == 0) q_tbl[pend_at] = pend;
        end else if (en) begin
            pend    = model_update(int'(state), int'(action), int'(next_state),
                                   int'(reward), int'(alpha), int'(gamma));
            pend_at = int'(state) * (1 << A_W) + int'(action);
            remain  = int'(N_ACT) + 2;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if (busy !== (remain > 0) || done !== (remain == 1) || result !== 16'(res_exp)) begin
                errors++;
                $display("FAIL cycle t=%0t busy=%b exp %b done=%b exp %b result=%0d exp %0d",
                         $time, busy, (remain > 0), done, (remain == 1), result, res_exp);
            end
        end
    end

    task automatic check_val(input string nm, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic wait_done(output bit got, output int n);
        got = 1'b0;
        n   = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic drive(input int s, input int a, input int sn, input int r,
                         input int al, input int g);
        state      = S_W'(s);
        action     = A_W'(a);
        next_state = S_W'(sn);
        reward     = Q_W'(r);
        alpha      = F_W'(al);
        gamma      = F_W'(g);
    endtask

    // One update; inputs are scrambled right after acceptance
    task automatic run_upd(input string nm, input int s, input int a, input int sn,
                           input int r, input int al, input int g, input int exp);
        bit got;
        int n;
        drive(s, a, sn, r, al, g);
        en = 1'b1;
        @(posedge clk);
        #1;
        en         = 1'b0;
        state      = S_W'($urandom);
        action     = A_W'($urandom);
        next_state = S_W'($urandom);
        reward     = Q_W'($urandom);
        alpha      = F_W'($urandom);
        gamma      = F_W'($urandom);
        wait_done(got, n);
        check_val({nm, "_done_seen"}, 32'(got), 32'(1));
        check_val({nm, "_latency"}, n, int'(N_ACT) + 2);
        check_val({nm, "_result"}, result, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit got;
        int n;
        rst = 1'b1;
        en  = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("reset_result", result, 0);
        check_val("reset_busy", 32'(busy), 0);
        check_val("reset_done", 32'(done), 0);
        @(posedge clk);
        #1;

        run_upd("empty_zero", 1, 0, 2, 0, 8, 14, 0);
        run_upd("r100_first", 24, 1, 25, 100, 8, 14, 50);
        run_upd("r100_repeat", 24, 1, 25, 100, 8, 14, 75);
        run_upd("preset_25_1", 25, 1, 26, 100, 8, 14, 50);
        run_upd("discounted_max", 20, 1, 25, 0, 8, 14, 21);
        run_upd("alpha_zero", 24, 1, 25, 100, 0, 14, 75);
        run_upd("neg_first", 2, 1, 3, -100, 8, 14, -50);
        run_upd("neg_repeat", 2, 1, 3, -100, 8, 14, -75);
        run_upd("sat_1", 30, 2, 30, 32767, 15, 15, 30719);
        run_upd("sat_2", 30, 2, 30, 32767, 15, 15, 32767);
        run_upd("sat_3", 30, 2, 30, 32767, 15, 15, 32767);
        run_upd("sat_4", 30, 2, 30, 32767, 15, 15, 32767);
        run_upd("latched_inputs", 5, 0, 6, 160, 8, 0, 80);

        // en held high: second update follows immediately
        drive(40, 3, 41, 64, 4, 0);
        en = 1'b1;
        wait_done(got, n);
        check_val("b2b_first_result", result, 16);
        wait_done(got, n);
        check_val("b2b_second_seen", 32'(got), 1);
        check_val("b2b_gap", n, int'(N_ACT) + 3);
        check_val("b2b_second_result", result, 28);
        @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of SCAN aborts the update
        drive(10, 3, 11, 500, 8, 14);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("abort_result", result, 0);
        check_val("abort_busy", 32'(busy), 0);
        check_val("abort_done", 32'(done), 0);
        @(posedge clk);
        #1;
        run_upd("abort_entry_empty", 10, 3, 11, 500, 0, 14, 0);
        run_upd("table_cleared", 24, 1, 25, 100, 8, 14, 50);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
